// File: rtl/bht_predictor.sv
`default_nettype none
// ============================================================================
// Module   : bht_predictor
// Purpose  : Gshare-style branch history table. Fetch-side prediction is
//            purely combinational; commit-side training updates a saturating
//            counter table, the global history register and the statistics.
// Revision : 1.0 - initial release
// ============================================================================
module bht_predictor #(
   parameter int ENTRIES = 256,
   parameter int CNT_W   = 2,
   parameter int HIST_W  = 8,
   parameter int ADDR_W  = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rdy,
   input  logic [ADDR_W-1:0]           pc_cur,
   input  logic [31:0]                 ins_cur,
   output logic [ADDR_W-1:0]           pc_pred,
   output logic                        predict_jump,
   output logic [$clog2(ENTRIES)-1:0]  pred_index,
   input  logic                        enable_from_rob,
   input  logic [$clog2(ENTRIES)-1:0]  train_index,
   input  logic                        if_jump,
   input  logic [31:0]                 code,
   input  logic                        train_mispredict,
   output logic [31:0]                 stat_branches,
   output logic [31:0]                 stat_misses
);

   localparam int IDX_W = $clog2(ENTRIES);
   // History register keeps at least one bit so the flop exists when history is disabled.
   localparam int GHR_W = (HIST_W > 0) ? HIST_W : 1;

   localparam logic [6:0]       c_op_branch = 7'b1100011;
   localparam logic [6:0]       c_op_jal    = 7'b1101111;
   localparam logic [CNT_W-1:0] c_cnt_rst   = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

   logic [CNT_W-1:0]  cnt_q [ENTRIES];
   logic [CNT_W-1:0]  cnt_d [ENTRIES];
   logic [GHR_W-1:0]  ghr_q, ghr_d;
   logic [31:0]       stat_branches_q, stat_branches_d;
   logic [31:0]       stat_misses_q, stat_misses_d;

   logic [IDX_W-1:0]  w_hist_ext;
   logic [IDX_W-1:0]  w_index;
   logic [CNT_W-1:0]  w_cnt_rd;
   logic [CNT_W-1:0]  w_cnt_old;
   logic signed [31:0] w_b_imm;
   logic signed [31:0] w_j_imm;
   logic [ADDR_W-1:0] w_b_ext;
   logic [ADDR_W-1:0] w_j_ext;
   logic              w_train;
   logic              w_unused_code;

   // History contribution to the index; zero when history is disabled.
   generate
      if (HIST_W > 0) begin : g_hist
         assign w_hist_ext = IDX_W'(ghr_q);
      end else begin : g_no_hist
         assign w_hist_ext = '0;
      end
   endgenerate

   assign w_index  = pc_cur[IDX_W+1:2] ^ w_hist_ext;
   assign w_cnt_rd = cnt_q[w_index];

   // Immediates are built at 32 bits and then sign-extended or truncated to ADDR_W.
   assign w_b_imm = {{19{ins_cur[31]}}, ins_cur[31], ins_cur[7], ins_cur[30:25],
                     ins_cur[11:8], 1'b0};
   assign w_j_imm = {{11{ins_cur[31]}}, ins_cur[31], ins_cur[19:12], ins_cur[20],
                     ins_cur[30:21], 1'b0};
   assign w_b_ext = ADDR_W'(w_b_imm);
   assign w_j_ext = ADDR_W'(w_j_imm);

   // Only the opcode field of the committed word matters.
   assign w_unused_code = ^code[31:7];

   assign w_train   = rdy & enable_from_rob & (code[6:0] == c_op_branch);
   assign w_cnt_old = cnt_q[train_index];

   // Fetch-side prediction from the current (pre-update) table contents.
   always_comb begin
      predict_jump = 1'b0;
      pc_pred      = pc_cur + ADDR_W'(4);
      case (ins_cur[6:0])
         c_op_branch: begin
            if (w_cnt_rd[CNT_W-1]) begin
               predict_jump = 1'b1;
               pc_pred      = pc_cur + w_b_ext;
            end
         end
         c_op_jal: begin
            predict_jump = 1'b1;
            pc_pred      = pc_cur + w_j_ext;
         end
         default: ;
      endcase
   end

   assign pred_index    = w_index;
   assign stat_branches = stat_branches_q;
   assign stat_misses   = stat_misses_q;

   // Commit-side training: saturating counter, history shift and statistics.
   always_comb begin
      cnt_d           = cnt_q;
      ghr_d           = ghr_q;
      stat_branches_d = stat_branches_q;
      stat_misses_d   = stat_misses_q;
      if (w_train) begin
         if (if_jump) begin
            if (w_cnt_old != c_cnt_max) begin
               cnt_d[train_index] = w_cnt_old + CNT_W'(1);
            end
         end else begin
            if (w_cnt_old != '0) begin
               cnt_d[train_index] = w_cnt_old - CNT_W'(1);
            end
         end
         ghr_d           = GHR_W'({ghr_q, if_jump});
         stat_branches_d = stat_branches_q + 32'd1;
         if (train_mispredict) begin
            stat_misses_d = stat_misses_q + 32'd1;
         end
      end
   end

   // State registers; reset overrides any training in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= c_cnt_rst;
         end
         ghr_q           <= '0;
         stat_branches_q <= '0;
         stat_misses_q   <= '0;
      end else begin
         cnt_q           <= cnt_d;
         ghr_q           <= ghr_d;
         stat_branches_q <= stat_branches_d;
         stat_misses_q   <= stat_misses_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bht_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bht_predictor
// Purpose  : Scoreboard bench for bht_predictor against an abstract model of
//            counters, history and statistics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bht_predictor;

   localparam int ENTRIES = 256;
   localparam int CNT_W   = 2;
   localparam int HIST_W  = 8;
   localparam int ADDR_W  = 32;
   localparam int IDX_W   = 8;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_ALU  = 7'b0110011;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              rdy = 1'b0;
   logic [31:0]       pc_cur = '0;
   logic [31:0]       ins_cur = '0;
   logic [31:0]       pc_pred;
   logic              predict_jump;
   logic [IDX_W-1:0]  pred_index;
   logic              enable_from_rob = 1'b0;
   logic [IDX_W-1:0]  train_index = '0;
   logic              if_jump = 1'b0;
   logic [31:0]       code = '0;
   logic              train_mispredict = 1'b0;
   logic [31:0]       stat_branches;
   logic [31:0]       stat_misses;

   bht_predictor #(
      .ENTRIES(ENTRIES), .CNT_W(CNT_W), .HIST_W(HIST_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .pc_cur(pc_cur), .ins_cur(ins_cur),
      .pc_pred(pc_pred), .predict_jump(predict_jump), .pred_index(pred_index),
      .enable_from_rob(enable_from_rob), .train_index(train_index),
      .if_jump(if_jump), .code(code), .train_mispredict(train_mispredict),
      .stat_branches(stat_branches), .stat_misses(stat_misses)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc_pred;
      logic        pj;
      logic [7:0]  idx;
      logic [31:0] sb;
      logic [31:0] sm;
   } exp_t;

   exp_t sb_q[$];
   logic chk_en = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   // ---------------- reference model ----------------
   int          m_cnt [ENTRIES];
   int          m_ghr;
   int unsigned m_sb, m_sm;

   function automatic void model_reset();
      for (int i = 0; i < ENTRIES; i++) m_cnt[i] = (1 << (CNT_W - 1)) - 1;
      m_ghr = 0;
      m_sb  = 0;
      m_sm  = 0;
   endfunction

   function automatic int model_index(logic [31:0] pc);
      return (int'(pc >> 2) % ENTRIES) ^ m_ghr;
   endfunction

   function automatic void model_train(int idx, logic jmp, logic mis);
      int top;
      top = (1 << CNT_W) - 1;
      if (jmp) m_cnt[idx] = (m_cnt[idx] + 1 > top) ? top : m_cnt[idx] + 1;
      else     m_cnt[idx] = (m_cnt[idx] - 1 < 0) ? 0 : m_cnt[idx] - 1;
      m_ghr = (m_ghr * 2 + int'(jmp)) % (1 << HIST_W);
      m_sb  = m_sb + 1;
      if (mis) m_sm = m_sm + 1;
   endfunction

   function automatic int b_imm(logic [31:0] ins);
      int v;
      v = ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
      if (ins[31]) v = v - 8192;
      return v;
   endfunction

   function automatic int j_imm(logic [31:0] ins);
      int v;
      v = ins[31] * (1 << 20) + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
      if (ins[31]) v = v - (1 << 21);
      return v;
   endfunction

   function automatic logic [31:0] enc_b(int imm);
      logic [31:0] u;
      u = imm;
      return {u[12], u[10:5], 13'd0, u[4:1], u[11], OP_BR};
   endfunction

   function automatic logic [31:0] enc_j(int imm);
      logic [31:0] u;
      u = imm;
      return {u[20], u[10:1], u[11], u[19:12], 5'd0, OP_JAL};
   endfunction

   // Fetch PC whose table index equals x under the current model history.
   function automatic logic [31:0] pcx(int x);
      int i;
      i = (x ^ m_ghr) & (ENTRIES - 1);
      return 32'(i) << 2;
   endfunction

   // ---------------- stimulus ----------------
   task automatic cycle(input logic r, input logic rd, input logic [31:0] pc,
                        input logic [31:0] ins, input logic en, input logic [7:0] tidx,
                        input logic jmp, input logic [31:0] cd, input logic mis);
      exp_t e;
      int   idx;
      @(posedge clk);
      #1;
      rst = r; rdy = rd; pc_cur = pc; ins_cur = ins;
      enable_from_rob = en; train_index = tidx; if_jump = jmp;
      code = cd; train_mispredict = mis;
      if (!r) model_reset();
      idx       = model_index(pc);
      e.idx     = 8'(idx);
      e.pj      = 1'b0;
      e.pc_pred = pc + 32'd4;
      if (ins[6:0] == OP_BR && m_cnt[idx] >= (1 << (CNT_W - 1))) begin
         e.pj      = 1'b1;
         e.pc_pred = pc + 32'(b_imm(ins));
      end else if (ins[6:0] == OP_JAL) begin
         e.pj      = 1'b1;
         e.pc_pred = pc + 32'(j_imm(ins));
      end
      e.sb = 32'(m_sb);
      e.sm = 32'(m_sm);
      sb_q.push_back(e);
      chk_en = 1'b1;
      if (r && rd && en && cd[6:0] == OP_BR) model_train(int'(tidx), jmp, mis);
   endtask

   // ---------------- monitor ----------------
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (chk_en) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got no entry, expected one at %0t", $time);
         end else begin
            e = sb_q.pop_front();
            check("pc_pred", pc_pred, e.pc_pred);
            check("predict_jump", {31'd0, predict_jump}, {31'd0, e.pj});
            check("pred_index", {24'd0, pred_index}, {24'd0, e.idx});
            check("stat_branches", stat_branches, e.sb);
            check("stat_misses", stat_misses, e.sm);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] brb, nop, jalr, r32, r32b, pc, ins, cd;
      int          k;
      logic [6:0]  op;
      brb  = enc_b(16);
      nop  = 32'h0000_0013;
      jalr = {25'd0, OP_JALR};
      model_reset();
      repeat (3) @(posedge clk);

      // Reset state, then first fetch after release.
      cycle(0, 1, 32'h100, brb, 0, 0, 0, nop, 0);
      cycle(1, 1, 32'h100, brb, 0, 0, 0, nop, 0);

      // Two taken trains make index 0x40 predict taken.
      cycle(1, 1, 32'h300, nop, 1, 8'h40, 1, brb, 0);
      cycle(1, 1, 32'h300, nop, 1, 8'h40, 1, brb, 1);
      cycle(1, 1, pcx(8'h40), brb, 0, 0, 0, nop, 0);
      // Saturate, then one decrement still leaves it taken.
      cycle(1, 1, 32'h300, nop, 1, 8'h40, 1, brb, 0);
      cycle(1, 1, 32'h300, nop, 1, 8'h40, 0, brb, 1);
      cycle(1, 1, pcx(8'h40), brb, 0, 0, 0, nop, 0);
      cycle(1, 1, 32'h300, nop, 1, 8'h40, 0, brb, 0);
      cycle(1, 1, pcx(8'h40), brb, 0, 0, 0, nop, 0);

      // JAL wrap-around and JALR fall-through; JALR commit does not train.
      cycle(1, 1, 32'h8, enc_j(-16), 0, 0, 0, nop, 0);
      cycle(1, 1, 32'h200, jalr, 1, 8'h40, 1, jalr, 1);
      cycle(1, 1, 32'h200, jalr, 0, 0, 0, nop, 0);

      // Same-cycle read and train of one index.
      cycle(1, 1, pcx(8'h80), brb, 1, 8'h80, 1, brb, 0);
      cycle(1, 1, pcx(8'h80), brb, 0, 0, 0, nop, 0);

      // Frozen while rdy is low.
      for (int i = 0; i < 5; i++) cycle(1, 0, pcx(8'h80), brb, 1, 8'h80, 0, brb, 1);
      cycle(1, 1, pcx(8'h80), brb, 0, 0, 0, nop, 0);

      // Asynchronous reset mid-run with a training update in flight.
      cycle(0, 1, pcx(8'h80), brb, 1, 8'h80, 0, brb, 1);
      cycle(1, 1, 32'h200, brb, 0, 0, 0, nop, 0);

      // Randomized traffic concentrated on a few indices.
      for (int n = 0; n < 1500; n++) begin
         r32  = $urandom;
         r32b = $urandom;
         k    = $urandom_range(0, 7);
         pc   = {r32[31:10], 8'(pcx(k) >> 2), r32[1:0]};
         case ($urandom_range(0, 3))
            0:       op = OP_BR;
            1:       op = OP_JAL;
            2:       op = OP_JALR;
            default: op = OP_ALU;
         endcase
         if ($urandom_range(0, 1) == 0) op = OP_BR;
         ins = {r32b[31:7], op};
         r32 = $urandom;
         cd  = {r32[31:7], ($urandom_range(0, 4) != 0) ? OP_BR : OP_JAL};
         cycle($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0, pc, ins,
               1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), cd, 1'($urandom_range(0, 1)));
      end

      @(posedge clk);
      #1;
      chk_en = 1'b0;
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
